// File: rtl/sram_ctrl_if.sv
// Request/response bus between the load/store unit and the SRAM controller.
// The master side is the LSU; the slave side is the controller.
interface sram_ctrl_if;
  logic        i_req;
  logic        i_wren;
  logic [18:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_bmask;
  logic        o_ready;
  logic        o_ack;
  logic [31:0] o_rdata;

  modport master (
    output i_req, i_wren, i_addr, i_wdata, i_bmask,
    input  o_ready, o_ack, o_rdata
  );

  modport slave (
    input  i_req, i_wren, i_addr, i_wdata, i_bmask,
    output o_ready, o_ack, o_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// Splits one 32-bit LSU access into a low and a high 16-bit beat on an
// external asynchronous SRAM. Each beat is WAIT_CYC strobe cycles followed by
// one recovery cycle. Every SRAM pin is driven straight from a register.
module sram_ctrl #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  sram_ctrl_if.slave  bus,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  // Everything that leaves the chip on the SRAM side, kept as one register.
  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] dq;
    logic        dq_oe;
    logic        ce_n;
    logic        we_n;
    logic        oe_n;
    logic        lb_n;
    logic        ub_n;
  } pins_t;

  localparam pins_t PINS_IDLE = '{addr: '0, dq: '0, dq_oe: 1'b0, ce_n: 1'b1,
                                  we_n: 1'b1, oe_n: 1'b1, lb_n: 1'b1, ub_n: 1'b1};
  localparam logic [3:0] LAST_STB = 4'(WAIT_CYC - 1);
  localparam logic [3:0] LAST_CYC = 4'(WAIT_CYC);

  state_t      state;
  logic [3:0]  cnt;
  pins_t       pins;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [3:0]  bmask;
  logic        wren;
  logic        ready;
  logic        ack;
  logic [31:0] rdata;

  // Byte-offset bits are meaningless for word-aligned requests.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.i_addr[1:0];

  // Pin values for the first (strobe) cycle of a beat.
  function automatic pins_t beat_pins(input logic        hi,
                                      input logic        w,
                                      input logic [16:0] a,
                                      input logic [31:0] d,
                                      input logic [3:0]  m);
    pins_t p;
    p.addr  = {a, hi};
    p.dq    = hi ? d[31:16] : d[15:0];
    p.dq_oe = w;
    p.ce_n  = 1'b0;
    p.we_n  = ~w;
    p.oe_n  = w;
    p.lb_n  = w ? ~(hi ? m[2] : m[0]) : 1'b0;
    p.ub_n  = w ? ~(hi ? m[3] : m[1]) : 1'b0;
    return p;
  endfunction

  // Sequencer: accepts a request, runs the beats, and pulses ack.
  // NOTE: state and outputs use non-blocking assignments so every reader in
  // this block sees the values from before the edge, as the hardware does.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
      pins  <= PINS_IDLE;
      word  <= '0;
      wdata <= '0;
      bmask <= '0;
      wren  <= 1'b0;
      ready <= 1'b1;
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req) begin
            word  <= bus.i_addr[18:2];
            wdata <= bus.i_wdata;
            bmask <= bus.i_bmask;
            wren  <= bus.i_wren;
            ready <= 1'b0;
            cnt   <= '0;
            if (bus.i_wren && bus.i_bmask == 4'b0000) begin
              state <= DONE;
              ack   <= 1'b1;
            end else if (bus.i_wren && bus.i_bmask[1:0] == 2'b00) begin
              state <= HI;
              pins  <= beat_pins(1'b1, bus.i_wren, bus.i_addr[18:2],
                                 bus.i_wdata, bus.i_bmask);
            end else begin
              state <= LO;
              pins  <= beat_pins(1'b0, bus.i_wren, bus.i_addr[18:2],
                                 bus.i_wdata, bus.i_bmask);
            end
          end
        end
        LO, HI: begin
          if (cnt == LAST_CYC) begin
            cnt <= '0;
            if (state == LO && !(wren && bmask[3:2] == 2'b00)) begin
              state <= HI;
              pins  <= beat_pins(1'b1, wren, word, wdata, bmask);
            end else begin
              state <= DONE;
              pins  <= PINS_IDLE;
              ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_STB) begin
              // Strobes rise for the recovery cycle; address, data and lanes hold.
              pins.we_n <= 1'b1;
              pins.oe_n <= 1'b1;
              if (!wren) begin
                if (state == LO) rdata[15:0]  <= SRAM_DQ;
                else             rdata[31:16] <= SRAM_DQ;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the output enable for DQ is itself a register, so the bus turns
  // around exactly on clock edges with no combinational glitch.
  assign SRAM_DQ   = pins.dq_oe ? pins.dq : 16'hzzzz;
  assign SRAM_ADDR = pins.addr;
  assign SRAM_CE_N = pins.ce_n;
  assign SRAM_WE_N = pins.we_n;
  assign SRAM_OE_N = pins.oe_n;
  assign SRAM_LB_N = pins.lb_n;
  assign SRAM_UB_N = pins.ub_n;

  assign bus.o_ready = ready;
  assign bus.o_ack   = ack;
  assign bus.o_rdata = rdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one instance at WAIT_CYC=1 and one at
// WAIT_CYC=3, each attached to a small behavioural asynchronous SRAM.
// DQ has a pull-up so a released bus reads 16'hFFFF.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  sram_ctrl_if bus1 ();
  sram_ctrl_if bus3 ();

  wire  [15:0] dq1, dq3;
  logic [17:0] addr1, addr3;
  logic ce1, we1, oe1, lb1, ub1;
  logic ce3, we3, oe3, lb3, ub3;

  pullup pu_dq1 (dq1);
  pullup pu_dq3 (dq3);

  sram_ctrl #(.WAIT_CYC(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1),
    .SRAM_ADDR(addr1), .SRAM_DQ(dq1), .SRAM_CE_N(ce1), .SRAM_WE_N(we1),
    .SRAM_OE_N(oe1), .SRAM_LB_N(lb1), .SRAM_UB_N(ub1)
  );

  sram_ctrl #(.WAIT_CYC(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .bus(bus3),
    .SRAM_ADDR(addr3), .SRAM_DQ(dq3), .SRAM_CE_N(ce3), .SRAM_WE_N(we3),
    .SRAM_OE_N(oe3), .SRAM_LB_N(lb3), .SRAM_UB_N(ub3)
  );

  // Behavioural SRAMs: drive DQ while read-enabled, store enabled lanes while written.
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];

  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[addr1[7:0]] : 16'hzzzz;
  assign dq3 = (!ce3 && !oe3 && we3) ? mem3[addr3[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce1 && !we1) begin
      if (!lb1) mem1[addr1[7:0]][7:0]  <= dq1[7:0];
      if (!ub1) mem1[addr1[7:0]][15:8] <= dq1[15:8];
    end
  end

  initial begin
    mem3[8] = 16'h1234;
    mem3[9] = 16'h5678;
  end

  // Observation mux onto whichever instance is under test.
  logic sel3;
  wire [17:0] ob_addr  = sel3 ? addr3 : addr1;
  wire [15:0] ob_dq    = sel3 ? dq3 : dq1;
  wire        ob_ce    = sel3 ? ce3 : ce1;
  wire        ob_we    = sel3 ? we3 : we1;
  wire        ob_oe    = sel3 ? oe3 : oe1;
  wire        ob_lb    = sel3 ? lb3 : lb1;
  wire        ob_ub    = sel3 ? ub3 : ub1;
  wire        ob_rdy   = sel3 ? bus3.o_ready : bus1.o_ready;
  wire        ob_ack   = sel3 ? bus3.o_ack : bus1.o_ack;
  wire [31:0] ob_rdata = sel3 ? bus3.o_rdata : bus1.o_rdata;

  // Per-cycle trace of one transaction; index k = k-th cycle after acceptance.
  logic [17:0] t_addr [1:40];
  logic [15:0] t_dq   [1:40];
  logic [40:1] t_ce, t_we, t_oe, t_lb, t_ub, t_rdy;
  int          lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle (longer if hold > 0), then trace until ack.
  task automatic issue(input logic w, input logic [18:0] a, input logic [31:0] d,
                       input logic [3:0] m, input int hold);
    @(negedge clk);
    if (sel3) begin
      bus3.i_wren = w; bus3.i_addr = a; bus3.i_wdata = d; bus3.i_bmask = m; bus3.i_req = 1'b1;
    end else begin
      bus1.i_wren = w; bus1.i_addr = a; bus1.i_wdata = d; bus1.i_bmask = m; bus1.i_req = 1'b1;
    end
    t_ce = '1; t_we = '1; t_oe = '1; t_lb = '1; t_ub = '1; t_rdy = '1;
    lat = 0;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k > hold) begin
        bus1.i_req = 1'b0;
        bus3.i_req = 1'b0;
      end
      t_addr[k] = ob_addr;
      t_dq[k]   = ob_dq;
      t_ce[k]   = ob_ce;
      t_we[k]   = ob_we;
      t_oe[k]   = ob_oe;
      t_lb[k]   = ob_lb;
      t_ub[k]   = ob_ub;
      t_rdy[k]  = ob_rdy;
      if (ob_ack) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int ce_low;
    int ack_seen;
    sel3 = 1'b0;
    rst  = 1'b1;
    bus1.i_req = 1'b0; bus1.i_wren = 1'b0; bus1.i_addr = '0; bus1.i_wdata = '0; bus1.i_bmask = '0;
    bus3.i_req = 1'b0; bus3.i_wren = 1'b0; bus3.i_addr = '0; bus3.i_wdata = '0; bus3.i_bmask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", ob_rdy, 1);
    check("rst_ack", ob_ack, 0);
    check("rst_rdata", ob_rdata, 0);
    check("rst_strobes", {ob_ce, ob_we, ob_oe, ob_lb, ob_ub}, 5'b11111);
    check("rst_addr", ob_addr, 0);
    check("rst_dq", ob_dq, 16'hFFFF);

    // Full write, WAIT_CYC=1
    issue(1'b1, 19'h00010, 32'hDEADBEEF, 4'b1111, 0);
    check("wr_lat", lat, 5);
    check("wr_we", t_we[5:1], 5'b11010);
    check("wr_ce", t_ce[5:1], 5'b10000);
    check("wr_oe", t_oe[5:1], 5'b11111);
    check("wr_ready", t_rdy[5:1], 5'b00000);
    check("wr_lanes", {t_lb[4:1], t_ub[4:1]}, 8'h00);
    check("wr_lo_addr", {t_addr[1], t_addr[2]}, {18'h00008, 18'h00008});
    check("wr_hi_addr", {t_addr[3], t_addr[4]}, {18'h00009, 18'h00009});
    check("wr_lo_dq", {t_dq[1], t_dq[2]}, 32'hBEEFBEEF);
    check("wr_hi_dq", {t_dq[3], t_dq[4]}, 32'hDEADDEAD);
    check("wr_done_dq", t_dq[5], 16'hFFFF);
    check("wr_mem", {mem1[9], mem1[8]}, 32'hDEADBEEF);

    // Full read, WAIT_CYC=1
    issue(1'b0, 19'h00010, 32'h0, 4'b0000, 0);
    check("rd_lat", lat, 5);
    check("rd_rdata", ob_rdata, 32'hDEADBEEF);
    check("rd_oe", t_oe[5:1], 5'b11010);
    check("rd_we", t_we[5:1], 5'b11111);
    check("rd_lanes", {t_lb[4:1], t_ub[4:1]}, 8'h00);
    check("rd_addr", {t_addr[1], t_addr[3]}, {18'h00008, 18'h00009});
    check("rd_dq_released", {t_dq[2], t_dq[4], t_dq[5]}, 48'hFFFF_FFFF_FFFF);

    // Single-byte write confined to the high half-word
    issue(1'b1, 19'h00010, 32'h00AA0000, 4'b0100, 0);
    check("bw_lat", lat, 3);
    check("bw_addr", t_addr[1], 18'h00009);
    check("bw_lanes", {t_lb[1], t_ub[1]}, 2'b01);
    check("bw_dq", t_dq[1], 16'h00AA);
    check("bw_we", t_we[3:1], 3'b110);
    check("bw_ce", t_ce[3:1], 3'b100);
    issue(1'b0, 19'h00010, 32'h0, 4'b0000, 0);
    check("bw_readback", ob_rdata, 32'hDEAABEEF);

    // Empty write mask, request held while busy
    issue(1'b1, 19'h00010, 32'h12345678, 4'b0000, 1);
    check("nw_lat", lat, 1);
    check("nw_ce", t_ce[1], 1);
    @(negedge clk);
    bus1.i_req = 1'b0;
    check("nw_ready_back", ob_rdy, 1);
    ce_low = 0;
    ack_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (!ob_ce) ce_low++;
      if (ob_ack) ack_seen++;
      @(negedge clk);
    end
    check("nw_no_access", ce_low, 0);
    check("nw_no_ack", ack_seen, 0);
    check("nw_mem", {mem1[9], mem1[8]}, 32'hDEAABEEF);

    // Read with WAIT_CYC=3
    sel3 = 1'b1;
    issue(1'b0, 19'h00010, 32'h0, 4'b0000, 0);
    check("w3_lat", lat, 9);
    check("w3_oe", t_oe[9:1], 9'h188);
    check("w3_ce", t_ce[9:1], 9'h100);
    check("w3_addr", {t_addr[1], t_addr[4], t_addr[5]}, {18'h00008, 18'h00008, 18'h00009});
    check("w3_rdata", ob_rdata, 32'h56781234);
    sel3 = 1'b0;

    // Reset during the HI strobe of a write
    @(negedge clk);
    bus1.i_wren = 1'b1; bus1.i_addr = 19'h00010; bus1.i_wdata = 32'h11112222;
    bus1.i_bmask = 4'b1111; bus1.i_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mr_in_hi", {ob_we, ob_addr}, {1'b0, 18'h00009});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_strobes", {ob_ce, ob_we, ob_oe, ob_lb, ob_ub}, 5'b11111);
    check("mr_dq", ob_dq, 16'hFFFF);
    check("mr_ready", ob_rdy, 1);
    check("mr_ack", ob_ack, 0);
    check("mr_rdata", ob_rdata, 0);
    check("mr_addr", ob_addr, 0);

    issue(1'b1, 19'h00020, 32'hCAFEF00D, 4'b1111, 0);
    check("mr_wr_lat", lat, 5);
    issue(1'b0, 19'h00020, 32'h0, 4'b0000, 0);
    check("mr_rd_lat", lat, 5);
    check("mr_rd_rdata", ob_rdata, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Downstream of the load/store unit: converts one 32-bit LSU memory request into two 16-bit accesses on the external 256K x 16 asynchronous SRAM.
- Drives the SRAM_ADDR/DQ/CE_N/WE_N/OE_N/LB_N/UB_N pins with registered, glitch-free strobes.
- Returns read data and a one-cycle completion pulse. The LSU stalls the core on o_ready=0.

Parameters:
- WAIT_CYC, 1, strobe-active cycles per 16-bit beat (legal range 1..15; 4-bit counter).

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req  in  1  request strobe; accepted when i_req & o_ready
- i_wren  in  1  1 = write, 0 = read
- i_addr  in  19  byte address; [1:0] ignored (word aligned)
- i_wdata  in  32  store data, already lane-aligned by the LSU
- i_bmask  in  4  write byte enables; bit n = byte n; ignored for reads
- o_ready  out  1  idle, can accept a request
- o_ack  out  1  one-cycle pulse when the request completes
- o_rdata  out  32  read word; valid from the o_ack cycle until the next accepted read
- SRAM_ADDR  out  18  SRAM half-word address
- SRAM_DQ  inout  16  SRAM data; driven only during write beats, else high-Z
- SRAM_CE_N  out  1  chip enable, low active
- SRAM_WE_N  out  1  write enable, low active
- SRAM_OE_N  out  1  output enable, low active
- SRAM_LB_N  out  1  lower byte enable, low active
- SRAM_UB_N  out  1  upper byte enable, low active

Behaviour:
- Reset (synchronous, i_rst=1 at an edge), from any state including mid-beat:
  - state=IDLE, o_ready=1, o_ack=0, o_rdata=0.
  - CE_N/WE_N/OE_N/LB_N/UB_N=1, SRAM_ADDR=0, DQ released.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - o_ready=1.
  - On i_req at an edge, latch addr/wdata/bmask/wren and drop o_ready.
  - Next state: LO; or HI if write with bmask[1:0]=00; or DONE if write with bmask=0000.
- Beat structure (LO and HI): WAIT_CYC+1 cycles, counted by a counter cleared on beat entry.
  - Strobe phase (first WAIT_CYC cycles): CE_N=0; OE_N=0 for reads, WE_N=0 for writes.
  - Recovery cycle (last cycle): CE_N=0, OE_N=WE_N=1; ADDR, DQ and lane enables held.
- LO beat lanes:
  - SRAM_ADDR={addr[18:2],0}; DQ=wdata[15:0] on writes.
  - LB_N=~bmask[0], UB_N=~bmask[1] on writes; LB_N=UB_N=0 on reads.
- HI beat lanes:
  - SRAM_ADDR={addr[18:2],1}; DQ=wdata[31:16] on writes.
  - LB_N=~bmask[2], UB_N=~bmask[3] on writes; LB_N=UB_N=0 on reads.
- Read capture: SRAM_DQ is sampled at the edge ending the last strobe cycle. LO fills o_rdata[15:0], HI fills o_rdata[31:16].
- Transitions out of a beat:
  - After LO: to HI, or to DONE if write with bmask[3:2]=00.
  - Reads always perform both beats.
- DONE (one cycle): o_ack=1, strobes high, DQ released; then IDLE, where o_ready=1 again.
- i_req while o_ready=0 is ignored, with no queuing; the requester re-asserts after o_ack.
- Latency, from the accepting edge to the o_ack cycle:
  - Two beats: 2*(WAIT_CYC+1)+1 cycles (5 at WAIT_CYC=1).
  - One beat: WAIT_CYC+2.
  - Empty write mask: 1.
- All pin outputs come straight from registers. WE_N and OE_N are never low in the same cycle. CE_N is high in IDLE and DONE.

Test Plan:
- Reset, then write addr 0x00010, data 0xDEADBEEF, bmask 1111 at WAIT_CYC=1:
  - LO: ADDR 0x00008, DQ 0xBEEF, WE_N low for 1 cycle.
  - HI: ADDR 0x00009, DQ 0xDEAD.
  - o_ack 5 cycles after acceptance; o_ready low throughout.
- Read addr 0x00010 against a behavioural SRAM model: OE_N low in both beats, LB_N=UB_N=0, o_rdata=0xDEADBEEF at o_ack, DQ never driven.
- Byte write addr 0x00010, data 0x00AA0000, bmask 0100:
  - Only the HI beat runs: ADDR 0x00009, LB_N=0, UB_N=1, DQ 0x00AA; ack after 3 cycles.
  - Readback gives 0xDEAABEEF.
- Write with bmask 0000: o_ack the next cycle, CE_N stays 1. A second i_req while busy produces no extra access.
- WAIT_CYC=3 read: each beat has 3 OE_N-low cycles plus 1 recovery cycle; o_ack at cycle 9.
- Assert i_rst during the HI strobe of a write: the next cycle shows all strobes 1, DQ high-Z, o_ready=1, o_ack=0, o_rdata=0. A new request then completes normally.
